// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the RAM macro side of the memory arbiter.
// The slave modport is the arbiter's view; the master modport drives requests and RAM read data.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              done0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              done1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, done0, rdata0,
        output gnt1, done1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, done0, rdata0,
        input  gnt1, done1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM between the core (port 0) and the loader (port 1).
// Each transaction is IDLE -> ACCESS (MEM_LAT cycles) -> DONE (1 cycle) -> IDLE.
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic              capture;

    logic [1:0]        req_w;
    logic [1:0]        we_w;
    logic [1:0]        gnt_w;
    logic [1:0]        done_w;
    logic [ADDR_W-1:0] addr_w  [2];
    logic [DATA_W-1:0] wdata_w [2];
    logic [DATA_W-1:0] rdata_q [2];

    assign req_w      = {bus.req1, bus.req0};
    assign we_w       = {bus.we1, bus.we0};
    assign addr_w[0]  = bus.addr0;
    assign addr_w[1]  = bus.addr1;
    assign wdata_w[0] = bus.wdata0;
    assign wdata_w[1] = bus.wdata1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_w) begin
                    // Contention goes to the priority port; the loser gets priority next time.
                    owner_d = (&req_w) ? prio_q : req_w[1];
                    prio_d  = ~owner_d;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                    capture = ~we_w[owner_q];
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rdata_q[gi] <= '0;
                end else if (capture && (owner_q == 1'(gi))) begin
                    rdata_q[gi] <= bus.mem_rdata;
                end
            end
            assign gnt_w[gi]  = (state_q != IDLE) && (owner_q == 1'(gi));
            assign done_w[gi] = (state_q == DONE) && (owner_q == 1'(gi));
        end
    endgenerate

    assign bus.gnt0   = gnt_w[0];
    assign bus.gnt1   = gnt_w[1];
    assign bus.done0  = done_w[0];
    assign bus.done1  = done_w[1];
    assign bus.rdata0 = rdata_q[0];
    assign bus.rdata1 = rdata_q[1];
    assign bus.busy   = (state_q != IDLE);

    // Address/data are driven only while the RAM is enabled, zero otherwise.
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = bus.mem_en && we_w[owner_q];
    assign bus.mem_addr  = bus.mem_en ? addr_w[owner_q]  : '0;
    assign bus.mem_wdata = bus.mem_en ? wdata_w[owner_q] : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a transaction-level reference model;
// two extra instances cover the MEM_LAT=1 and MEM_LAT=15 builds.
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter_if if1 ();
    mem_arbiter_if if15 ();

    mem_arbiter #(.MEM_LAT(LAT)) dut   (.clk_i(clk), .rst_i(rst), .bus(bus));
    mem_arbiter #(.MEM_LAT(1))   dut1  (.clk_i(clk), .rst_i(rst), .bus(if1));
    mem_arbiter #(.MEM_LAT(15))  dut15 (.clk_i(clk), .rst_i(rst), .bus(if15));

    function automatic logic [15:0] init_val(logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    // RAM macro: unwritten locations read as init_val
    logic [15:0] ram   [0:255];
    bit          valid [0:255];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_addr[7:0]]   <= bus.mem_wdata;
            valid[bus.mem_addr[7:0]] <= 1'b1;
        end
    end
    assign bus.mem_rdata  = valid[bus.mem_addr[7:0]] ? ram[bus.mem_addr[7:0]] : init_val(bus.mem_addr[7:0]);
    assign if1.mem_rdata  = 16'h3C3C;
    assign if15.mem_rdata = 16'hC3C3;

    // Reference model: m_t = cycles since grant (0 idle, 1..LAT access, LAT+1 done)
    int          m_t;
    bit          m_owner, m_prio, m_we;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata [2];
    logic [15:0] shadow  [0:255];

    int n_pass = 0, n_fail = 0, n_total = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_owner = 1'b0; m_prio = 1'b0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_t == 0) begin
            if (bus.req0 || bus.req1) begin
                m_owner = (bus.req0 && bus.req1) ? m_prio : bus.req1;
                m_prio  = !m_owner;
                m_we    = m_owner ? bus.we1    : bus.we0;
                m_addr  = m_owner ? bus.addr1  : bus.addr0;
                m_wdata = m_owner ? bus.wdata1 : bus.wdata0;
                m_t     = 1;
            end
        end else if (m_t <= LAT) begin
            if (m_t == LAT) begin
                if (m_we) shadow[m_addr[7:0]] = m_wdata;
                else      m_rdata[m_owner]    = shadow[m_addr[7:0]];
            end
            m_t++;
        end else begin
            m_t = 0;
        end
    endtask

    task automatic check_model();
        bit en;
        en = (m_t >= 1) && (m_t <= LAT);
        chk("busy",      bus.busy,      m_t != 0);
        chk("gnt0",      bus.gnt0,      (m_t != 0) && !m_owner);
        chk("gnt1",      bus.gnt1,      (m_t != 0) && m_owner);
        chk("done0",     bus.done0,     (m_t == LAT + 1) && !m_owner);
        chk("done1",     bus.done1,     (m_t == LAT + 1) && m_owner);
        chk("mem_en",    bus.mem_en,    en);
        chk("mem_we",    bus.mem_we,    en && m_we);
        chk("mem_addr",  bus.mem_addr,  en ? m_addr : 16'h0);
        chk("mem_wdata", bus.mem_wdata, en ? m_wdata : 16'h0);
        chk("rdata0",    bus.rdata0,    m_rdata[0]);
        chk("rdata1",    bus.rdata1,    m_rdata[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic set_port(int p, logic r, logic w, logic [15:0] a, logic [15:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && m_t != 0; i++) cycle();
        chk("idle_timeout", bus.busy, 1'b0);
    endtask

    initial begin
        int cnt_a, cnt_b, starts, last_start, d1, d15, en1, en15;
        bit prev_busy, got;
        logic r;
        bit dn;

        for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        if1.req0 = 0; if1.we0 = 0; if1.addr0 = 0; if1.wdata0 = 0;
        if1.req1 = 0; if1.we1 = 0; if1.addr1 = 0; if1.wdata1 = 0;
        if15.req0 = 0; if15.we0 = 0; if15.addr0 = 0; if15.wdata0 = 0;
        if15.req1 = 0; if15.we1 = 0; if15.addr1 = 0; if15.wdata1 = 0;

        // Reset state
        #2;
        model_reset();
        check_model();
        cycle();
        cycle();
        rst = 1'b0;

        // Single read of 0x0010 on port 0
        set_port(0, 1, 0, 16'h0010, 16'h0);
        cycle(); chk("rd_gnt0_t1", bus.gnt0, 1'b1); chk("rd_en_t1", bus.mem_en, 1'b1);
        cycle(); chk("rd_en_t2", bus.mem_en, 1'b1);
        cycle(); chk("rd_done0_t3", bus.done0, 1'b1); chk("rd_rdata0", bus.rdata0, 16'hBEEF);
        chk("rd_en_t3", bus.mem_en, 1'b0);
        set_port(0, 0, 0, 16'h0010, 16'h0);
        cycle(); chk("rd_busy_t4", bus.busy, 1'b0);

        // Single write on port 1, then read it back on port 0
        set_port(1, 1, 1, 16'h0005, 16'h1234);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (bus.mem_we) cnt_a++;
            if (bus.done1) begin cnt_b++; bus.req1 = 1'b0; end
        end
        chk("wr_we_cycles", cnt_a, 2);
        chk("wr_done1_pulses", cnt_b, 1);
        chk("wr_rdata1_kept", bus.rdata1, 16'h0);
        set_port(0, 1, 0, 16'h0005, 16'h0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            cycle();
            if (bus.done0) begin
                got = 1'b1;
                chk("wr_readback", bus.rdata0, 16'h1234);
                bus.req0 = 1'b0;
            end
        end
        chk("wr_readback_seen", got, 1'b1);
        wait_idle();

        // Owner drops req0 mid-access while req1 becomes pending
        set_port(0, 1, 0, 16'h0020, 16'h0);
        cycle();
        bus.req0 = 1'b0;
        set_port(1, 1, 0, 16'h0021, 16'h0);
        cycle();
        cycle(); chk("drop_done0_t3", bus.done0, 1'b1);
        cycle(); chk("drop_gnt1_t4", bus.gnt1, 1'b0);
        cycle(); chk("drop_gnt1_t5", bus.gnt1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (bus.done1) bus.req1 = 1'b0;
        end
        wait_idle();

        // Reset in the middle of a write
        set_port(0, 1, 1, 16'h0030, 16'h5555);
        cycle();
        cycle(); chk("rst_we_before", bus.mem_we, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_gnt0", bus.gnt0, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rdata0", bus.rdata0, 16'h0);
        shadow[8'h30] = 16'h5555;  // one write edge had already landed in the RAM
        bus.req0 = 1'b0;
        cycle();
        rst = 1'b0;

        // Both ports held after reset: grants alternate starting with port 0
        set_port(0, 1, 0, 16'h0040, 16'h0);
        set_port(1, 1, 0, 16'h0041, 16'h0);
        prev_busy = bus.busy; starts = 0; last_start = 0;
        for (int c = 1; c <= 40 && starts < 4; c++) begin
            cycle();
            if (bus.busy && !prev_busy) begin
                chk("alt_owner", bus.gnt1, 32'(starts % 2));
                if (starts > 0) chk("alt_period", c - last_start, LAT + 2);
                last_start = c;
                starts++;
            end
            prev_busy = bus.busy;
        end
        chk("alt_grants", starts, 4);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_idle();

        // MEM_LAT=1 and MEM_LAT=15 builds
        if1.addr0 = 16'h0007;  if1.req0 = 1'b1;
        if15.addr0 = 16'h0007; if15.req0 = 1'b1;
        d1 = 0; d15 = 0; en1 = 0; en15 = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (if1.mem_en)  en1++;
            if (if15.mem_en) en15++;
            if (if1.done0 && d1 == 0)   begin d1 = k;  if1.req0 = 1'b0;  end
            if (if15.done0 && d15 == 0) begin d15 = k; if15.req0 = 1'b0; end
        end
        chk("lat1_done", d1, 2);
        chk("lat15_done", d15, 16);
        chk("lat1_en_width", en1, 1);
        chk("lat15_en_width", en15, 15);
        chk("lat1_rdata", if1.rdata0, 16'h3C3C);
        chk("lat15_rdata", if15.rdata0, 16'hC3C3);

        // Random traffic on both ports against the model
        for (int c = 0; c < 300; c++) begin
            cycle();
            for (int p = 0; p < 2; p++) begin
                r  = (p == 0) ? bus.req0 : bus.req1;
                dn = (m_t == LAT + 1) && (m_owner == p[0]);
                if (r && dn)
                    set_port(p, 1'($urandom % 2), 1'($urandom % 2), 16'($urandom % 32), 16'($urandom));
                else if (!r && ($urandom % 3 == 0))
                    set_port(p, 1'b1, 1'($urandom % 2), 16'($urandom % 32), 16'($urandom));
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 16-bit data RAM between the processor core (the control unit and datapath fetch/load/store path) and the external loader/readback port. It serialises accesses with round-robin priority, holds the RAM control lines stable for a fixed read latency, and returns read data and a one-cycle completion pulse to the winning requester. It sits between the core's memory interface, the loader and the RAM macro.

## Interface
- MEM_LAT, 2, RAM access cycles per transaction; legal range 1..15.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req0  in  1  core request; held high until done0.
- we0  in  1  core write enable (1 = write, 0 = read); stable while req0 is high.
- addr0  in  ADDR_W  core address; stable while req0 is high.
- wdata0  in  DATA_W  core write data; stable while req0 is high.
- gnt0  out  1  core owns the RAM.
- done0  out  1  one-cycle completion pulse to the core.
- rdata0  out  DATA_W  core read data; valid when done0 is high, held afterwards.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1: loader port, with the same meaning as port 0.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid in the last ACCESS cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
- **States:**
  - IDLE: if any request is pending, grant one and go to ACCESS; otherwise stay in IDLE.
  - ACCESS: lasts MEM_LAT cycles, counted by a 4-bit counter, then go to DONE.
  - DONE: lasts 1 cycle, then go to IDLE.
- **Arbitration in IDLE:**
  - A single request wins outright.
  - If both req0 and req1 are high, the port indicated by the priority bit wins.
  - The priority bit points at the port that did not win the last grant.
  - After reset, the priority bit selects port 0.
- **Ownership:**
  - The owner register latches on the grant and stays fixed until the return to IDLE.
  - gntX = (state != IDLE) & (owner == X).
- **RAM signals:**
  - mem_addr and mem_wdata are muxed from the owner's inputs.
  - mem_en = ACCESS.
  - mem_we = ACCESS & owner's we.
  - In IDLE and DONE, mem_en = mem_we = 0.
  - In IDLE and DONE, mem_addr and mem_wdata are 0.
- **Read capture:**
  - On the last ACCESS cycle of a read, mem_rdata is registered into rdataX of the owner.
  - The other port's rdata is unchanged.
  - Writes do not modify either rdata.
- **done:** doneX is high only in DONE, and only for the owner.
- **Request dropped mid-transaction:** if the owner deasserts req before done, the transaction still completes, including the write and the done pulse. There is no abort.
- **Pending requester:** a request arriving while busy waits. It is evaluated on the next IDLE cycle.
- **Reset mid-transaction:**
  - state = IDLE, counter = 0, owner = 0, priority = port 0.
  - All outputs, including rdata0/1, go to 0 asynchronously.
  - The interrupted write is not completed. The RAM content at that address is undefined.

## Timing
- **Request in IDLE at cycle T (sampled on edge T):**
  - gnt rises at T+1.
  - ACCESS occupies T+1..T+MEM_LAT.
  - DONE is at T+MEM_LAT+1, with doneX and rdataX valid.
  - IDLE is at T+MEM_LAT+2.
- **Turnaround:**
  - Minimum transaction length is MEM_LAT+2 cycles.
  - Back-to-back sustained throughput is one transaction per MEM_LAT+2 cycles.
- **gntX duration:** gntX is high from T+1 through the DONE cycle inclusive, for MEM_LAT+1 cycles.
- **Outputs:** all outputs are registered-state derived, with no combinational path from req to gnt. mem_addr and mem_wdata have a combinational mux path from addrX and wdataX.
- **Reset values:** every output is 0.

## Test plan
- **Single read, MEM_LAT=2:**
  - Stimulus: req0=1, we0=0, addr0=0x0010 at T. RAM[0x0010]=0xBEEF.
  - Response: gnt0 high T+1..T+3; mem_en high at T+1 and T+2; done0 pulse at T+3; rdata0=0xBEEF; busy low at T+4.
- **Single write:**
  - Stimulus: req1=1, we1=1, addr1=0x0005, wdata1=0x1234.
  - Response: mem_we high for exactly 2 cycles; done1 pulse; a following port-0 read of 0x0005 returns 0x1234; rdata1 unchanged.
- **Simultaneous requests after reset, held continuously:**
  - Response: grants alternate 0,1,0,1.
  - Each grant lasts MEM_LAT+1 cycles, with one IDLE cycle between grants.
- **Request dropped mid-access:**
  - Stimulus: req0 deasserted at T+1.
  - Response: the transaction still completes with done0 at T+3.
  - With req1 pending, gnt1 rises at T+5.
- **Reset mid-access:**
  - Stimulus: reset asserted at T+2 of a write.
  - Response: mem_we, gnt0, busy and rdata0 go to 0 immediately.
  - After release, simultaneous requests grant port 0 first.
- **MEM_LAT=1 and MEM_LAT=15 builds:**
  - Response: the done pulse arrives exactly MEM_LAT+1 cycles after the request cycle; mem_en width equals MEM_LAT.
